// File: rtl/pb_edge_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : pb_edge_multi_if
//  Description : Button-side bundle for pb_edge_multi. Carries the raw button
//                levels into the debouncer and the per-channel debounced
//                state and event pulses back out to the control logic.
//
//  Signals (all N_CH wide, bit i belongs to channel i):
//    pb    : raw asynchronous button inputs
//    state : debounced pressed state (1 = pressed, polarity-independent)
//    prss  : one-cycle pulse on an accepted press
//    rls   : one-cycle pulse on an accepted release
//    lng   : one-cycle pulse on long press and on each auto-repeat
//
//  Modports:
//    slave  : debouncer side (drives state/prss/rls/lng, samples pb)
//    master : board/consumer side (drives pb, samples the results)
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface pb_edge_multi_if #(
    parameter int N_CH = 2
) ();
    logic [N_CH-1:0] pb;
    logic [N_CH-1:0] state;
    logic [N_CH-1:0] prss;
    logic [N_CH-1:0] rls;
    logic [N_CH-1:0] lng;

    modport slave (
        input  pb,
        output state,
        output prss,
        output rls,
        output lng
    );

    modport master (
        output pb,
        input  state,
        input  prss,
        input  rls,
        input  lng
    );
endinterface : pb_edge_multi_if
`default_nettype wire

// File: rtl/pb_edge_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pb_edge_multi
//  Description : Multi-channel push-button conditioner. Every channel has a
//                two-flop synchroniser, a counter-based debouncer with
//                selectable pressed polarity, registered press/release
//                pulses and long-press detection with optional auto-repeat.
//                Channels share clock and reset but are otherwise fully
//                independent.
//
//  Parameters:
//    N_CH       : number of button channels (>= 1)
//    DEB_CYC    : cycles a new level must persist before acceptance (>= 1)
//    LONG_CYC   : cycles of accepted press before the first long pulse (>= 1)
//    REPEAT_CYC : cycles between repeated long pulses while held, 0 = off
//    PB_POL     : pressed level on pb (1 = active-high, 0 = active-low)
//
//  Ports:
//    clk    : system clock
//    rst    : asynchronous active-low reset (0 = reset); deassertion is
//             expected to be synchronised by the integrator
//    pb_bus : pb_edge_multi_if.slave - pb in, state/prss/rls/lng out
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_edge_multi #(
    parameter int N_CH       = 2,
    parameter int DEB_CYC    = 1000000,
    parameter int LONG_CYC   = 100000000,
    parameter int REPEAT_CYC = 0,
    parameter int PB_POL     = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pb_edge_multi_if.slave    pb_bus
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values. Each counter is one bit wider than
    // strictly needed so the hold counter can park at LONG_CYC without wrap.
    // ------------------------------------------------------------------------
    localparam int c_dc_w = $clog2(DEB_CYC) + 1;
    localparam int c_hc_w = $clog2(LONG_CYC) + 1;
    localparam int c_rc_w = $clog2(REPEAT_CYC) + 1;

    localparam logic [c_dc_w-1:0] c_dc_last = c_dc_w'(DEB_CYC - 1);
    localparam logic [c_hc_w-1:0] c_hc_last = c_hc_w'(LONG_CYC - 1);
    // Parking value: the first long pulse has fired, repeat phase (if any).
    localparam logic [c_hc_w-1:0] c_hc_sat  = c_hc_w'(LONG_CYC);
    localparam logic [c_rc_w-1:0] c_rc_last =
        (REPEAT_CYC > 0) ? c_rc_w'(REPEAT_CYC - 1) : '0;

    localparam logic c_pol    = (PB_POL != 0);
    localparam logic c_rep_en = (REPEAT_CYC > 0);

    // Collected per-channel registered outputs.
    logic [N_CH-1:0] w_state;
    logic [N_CH-1:0] w_prss;
    logic [N_CH-1:0] w_rls;
    logic [N_CH-1:0] w_lng;

    assign pb_bus.state = w_state;
    assign pb_bus.prss  = w_prss;
    assign pb_bus.rls   = w_rls;
    assign pb_bus.lng   = w_lng;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic              r_s1;
        logic              r_s2;
        logic              r_state;
        logic              r_prss;
        logic              r_rls;
        logic              r_lng;
        logic [c_dc_w-1:0] r_dc;
        logic [c_hc_w-1:0] r_hc;
        logic [c_rc_w-1:0] r_rc;

        logic w_n;
        logic w_dc_done;
        logic w_press_evt;
        logic w_rel_evt;
        logic w_long_phase;
        logic w_hc_hit;
        logic w_rep_hit;

        // Normalised level: 1 means pressed regardless of board polarity.
        assign w_n          = ~(r_s2 ^ c_pol);
        assign w_dc_done    = (w_n != r_state) && (r_dc == c_dc_last);
        assign w_press_evt  = w_dc_done &&  w_n;
        assign w_rel_evt    = w_dc_done && !w_n;
        assign w_long_phase = (r_hc == c_hc_sat);
        assign w_hc_hit     = r_state && (r_hc == c_hc_last);
        assign w_rep_hit    = c_rep_en && r_state && w_long_phase
                              && (r_rc == c_rc_last);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                // Synchroniser starts at the released level so a button
                // held through reset is seen as a fresh press afterwards.
                r_s1    <= ~c_pol;
                r_s2    <= ~c_pol;
                r_state <= 1'b0;
                r_prss  <= 1'b0;
                r_rls   <= 1'b0;
                r_lng   <= 1'b0;
                r_dc    <= '0;
                r_hc    <= '0;
                r_rc    <= '0;
            end else begin
                r_s1   <= pb_bus.pb[g];
                r_s2   <= r_s1;

                r_prss <= w_press_evt;
                r_rls  <= w_rel_evt;
                // A release accepted on the same edge suppresses the long
                // pulse that would otherwise fire.
                r_lng  <= (w_hc_hit || w_rep_hit) && !w_rel_evt;

                // Debounce: any return to the accepted level restarts the
                // count, so glitches shorter than DEB_CYC leave no trace.
                if (w_n == r_state) begin
                    r_dc <= '0;
                end else if (r_dc == c_dc_last) begin
                    r_state <= w_n;
                    r_dc    <= '0;
                end else begin
                    r_dc <= r_dc + c_dc_w'(1);
                end

                // Hold counter: runs only while the accepted state is
                // pressed; parks at c_hc_sat after the first long pulse.
                if (!r_state || w_rel_evt) begin
                    r_hc <= '0;
                end else if (w_hc_hit) begin
                    r_hc <= c_hc_sat;
                end else if (!w_long_phase) begin
                    r_hc <= r_hc + c_hc_w'(1);
                end

                // Repeat counter: free-runs modulo REPEAT_CYC once parked.
                if (!c_rep_en || !r_state || w_rel_evt || !w_long_phase) begin
                    r_rc <= '0;
                end else if (r_rc == c_rc_last) begin
                    r_rc <= '0;
                end else begin
                    r_rc <= r_rc + c_rc_w'(1);
                end
            end
        end

        assign w_state[g] = r_state;
        assign w_prss[g]  = r_prss;
        assign w_rls[g]   = r_rls;
        assign w_lng[g]   = r_lng;
    end : g_ch

endmodule : pb_edge_multi
`default_nettype wire

// File: doc/pb_edge_multi.md
Name: pb_edge_multi

Overview:
- Parametrised multi-channel successor to the single-button push-button edge/debounce cell.
- Each channel has:
  - two-flop synchroniser;
  - counter-based debouncer with configurable polarity;
  - one-cycle press and release pulses;
  - long-press detection with optional auto-repeat.
- Sits between board push-buttons/switches and control logic (UART command block, user-reset request).
- All channels share one clock and reset.

Parameters:
- N_CH, 2: number of independent button channels (>=1).
- DEB_CYC, 1000000: consecutive cycles a new level must persist before being accepted (>=1; 10 ms at 100 MHz).
- LONG_CYC, 100000000: cycles of accepted press before the first long-press pulse (>=1).
- REPEAT_CYC, 0: cycles between repeated long-press pulses while held; 0 disables repeat.
- PB_POL, 1: pressed level on pb; 1 = active-high, 0 = active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- pb  in  N_CH  raw asynchronous button inputs
- state  out  N_CH  debounced pressed state, 1 = pressed, independent of PB_POL
- prss  out  N_CH  one-cycle pulse on accepted press
- rls  out  N_CH  one-cycle pulse on accepted release
- lng  out  N_CH  one-cycle pulse on long press and on each repeat

Behaviour:
- Reset (rst=0, asynchronous):
  - state, prss, rls, lng = 0.
  - Synchroniser flops load the released level (~PB_POL).
  - All counters = 0.
- Counter widths: $clog2 of the respective parameter +1. No counter ever wraps.
- Per channel, per clk rising edge. Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Synchroniser: s1 <= pb, s2 <= s1. Normalised level n = s2 XNOR PB_POL, so n = 1 means pressed.
- Debounce counter dc:
  - If n == state: dc <= 0.
  - Else if dc == DEB_CYC-1: state <= n, dc <= 0, and prss <= n (or rls <= ~n) for exactly one cycle.
  - Else: dc <= dc+1.
- Latency: a clean transition on pb sampled at edge k (first edge seeing the new level) gives state/prss/rls updated at edge k+DEB_CYC+1. These outputs are visible from edge k+DEB_CYC+1 onward, i.e. DEB_CYC+2 sampling edges.
- Glitch rejection: any pulse of n shorter than DEB_CYC cycles clears dc on return. It produces no state change and no pulse.
- prss/rls are registered, high for exactly 1 cycle, and never both high on one channel in the same cycle.
- Hold counter hc:
  - Cleared whenever state == 0, and in the cycle state goes 1.
  - While state == 1: hc increments until the long-press threshold.
  - When hc == LONG_CYC-1: lng pulses one cycle.
  - First lng is therefore at LONG_CYC cycles after the prss cycle.
- After the first lng:
  - REPEAT_CYC == 0: hc saturates; no further lng until release and a new press.
  - REPEAT_CYC > 0: a repeat counter pulses lng every REPEAT_CYC cycles while state stays 1.
- Release while hc is counting: hc clears and no lng is issued. A release in the same cycle a lng would fire suppresses that lng; rls wins.
- Reset mid-operation: everything returns to reset values immediately. If the button is still held after reset deassertion, a fresh prss is emitted after the normal debounce latency. No rls is generated for the press interrupted by reset.
- Reset deassertion is not synchronised inside this block; the integrator provides a synchronised deassertion.

Test Plan (N_CH=2, DEB_CYC=4, LONG_CYC=20, REPEAT_CYC=8, PB_POL=1 unless noted):
- Reset release, pb=00 for 50 cycles -> state=00; prss, rls, lng never asserted.
- pb[0] 0->1 sampled at edge 10, held -> state[0]=1 and prss[0]=1 for one cycle from edge 15; lng[0] at edge 35, then edges 43, 51, ...; channel 1 untouched.
- pb[1] high for 3 cycles then low, repeated 10 times -> no prss/rls/lng on channel 1. A 4-cycle high pulse yields prss then, after the low level is accepted, rls.
- Both pb bits rise on the same edge -> prss=11 in the same cycle. Release both together -> rls=11 in the same cycle.
- Held 15 cycles after prss, then released -> rls pulse, no lng. With REPEAT_CYC=0 and held 100 cycles -> exactly one lng.
- PB_POL=0, pb idle at 11: reset gives state=00. Drive pb[0] low -> prss[0] after DEB_CYC+2 edges. Assert rst while held -> all outputs 0 immediately; after deassert, prss[0] re-fires after debounce.
